// File: rtl/presence_alarm.sv
// presence_alarm
//   Turns the sonar stage's raw "object near" flag into a debounced presence
//   signal. On each new arrival it fires a one-cycle event strobe, bumps a
//   saturating arrival counter and plays a bounded square-wave beep burst.
//
// Ports
//   clk          system clock (64 MHz)
//   rst_n        asynchronous active-low reset
//   enable       block enable; low forces IDLE and clears all timers
//   near         object-near flag from the sonar stage (2-flop synchronized)
//   present      debounced presence (registered)
//   buzzer       piezo drive (registered)
//   event_pulse  one-cycle strobe per accepted arrival (registered)
//   event_count  saturating arrival count, cleared only by rst_n
module presence_alarm #(
   parameter int CNT_W       = 26,
   parameter int CONFIRM_CYC = 640000,
   parameter int RELEASE_CYC = 6400000,
   parameter int BEEP_HALF   = 32000,
   parameter int BEEP_CYC    = 32000000,
   parameter int EVT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             near,
   output logic             present,
   output logic             buzzer,
   output logic             event_pulse,
   output logic [EVT_W-1:0] event_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      ACTIVE  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_CYC - 1);
   localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BEEP_HALF - 1);
   localparam logic [CNT_W-1:0] BEEP_LIM  = CNT_W'(BEEP_CYC);
   localparam logic             BEEP_ON   = (BEEP_CYC != 0);

   state_t             state, state_d;
   logic               near_m, near_s;
   logic [CNT_W-1:0]   ctmr, ctmr_d;
   logic [CNT_W-1:0]   rtmr, rtmr_d;
   logic [CNT_W-1:0]   beep, beep_d;
   logic [CNT_W-1:0]   half, half_d;
   logic [CNT_W-1:0]   beep_inc;
   logic               buz_d, pres_d, pulse_d;
   logic [EVT_W-1:0]   cnt_d;

   assign beep_inc = beep + CNT_W'(1);

   // 2-flop synchronizer; everything downstream looks only at near_s
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         near_m <= 1'b0;
         near_s <= 1'b0;
      end else begin
         near_m <= near;
         near_s <= near_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ctmr        <= '0;
         rtmr        <= '0;
         beep        <= '0;
         half        <= '0;
         present     <= 1'b0;
         buzzer      <= 1'b0;
         event_pulse <= 1'b0;
         event_count <= '0;
      end else begin
         state       <= state_d;
         ctmr        <= ctmr_d;
         rtmr        <= rtmr_d;
         beep        <= beep_d;
         half        <= half_d;
         present     <= pres_d;
         buzzer      <= buz_d;
         event_pulse <= pulse_d;
         event_count <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      ctmr_d  = ctmr;
      rtmr_d  = rtmr;
      beep_d  = beep;
      half_d  = half;
      buz_d   = buzzer;
      pres_d  = present;
      pulse_d = 1'b0;
      cnt_d   = event_count;

      if (!enable) begin
         state_d = IDLE;
         ctmr_d  = '0;
         rtmr_d  = '0;
         beep_d  = '0;
         half_d  = '0;
         buz_d   = 1'b0;
         pres_d  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pres_d = 1'b0;
               buz_d  = 1'b0;
               if (near_s) begin
                  state_d = CONFIRM;
                  ctmr_d  = '0;
               end
            end
            CONFIRM: begin
               // a fall on the expiry edge still aborts: test near_s first
               if (!near_s) begin
                  state_d = IDLE;
                  ctmr_d  = '0;
               end else if (ctmr == CONF_LAST) begin
                  state_d = ACTIVE;
                  pulse_d = 1'b1;
                  if (event_count != '1) cnt_d = event_count + EVT_W'(1);
                  pres_d  = 1'b1;
                  buz_d   = BEEP_ON;
                  beep_d  = '0;
                  half_d  = '0;
               end else begin
                  ctmr_d = ctmr + CNT_W'(1);
               end
            end
            ACTIVE: begin
               pres_d = 1'b1;
               // the leaving edge does not advance the tone; it freezes as-is
               if (!near_s) begin
                  state_d = RELEASE;
                  rtmr_d  = '0;
                  buz_d   = 1'b0;
               end else if (beep < BEEP_LIM) begin
                  beep_d = beep_inc;
                  if (beep_inc == BEEP_LIM) begin
                     buz_d = 1'b0;
                  end else if (half == HALF_LAST) begin
                     buz_d  = ~buzzer;
                     half_d = '0;
                  end else begin
                     half_d = half + CNT_W'(1);
                  end
               end
            end
            RELEASE: begin
               pres_d = 1'b1;
               buz_d  = 1'b0;
               // a rise on the expiry edge keeps presence: test near_s first
               if (near_s) begin
                  state_d = ACTIVE;
                  buz_d   = (beep < BEEP_LIM);
               end else if (rtmr == REL_LAST) begin
                  state_d = IDLE;
                  pres_d  = 1'b0;
               end else begin
                  rtmr_d = rtmr + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               pres_d  = 1'b0;
               buz_d   = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_presence_alarm.sv
// tb_presence_alarm
//   Directed scenarios plus a randomized stretch, all checked every cycle
//   against a run-length model of the presence rules, with a few literal
//   expectations (latencies, beep pattern, saturation) pinning the model.
module tb_presence_alarm;

   localparam int C  = 8;
   localparam int R  = 16;
   localparam int H  = 2;
   localparam int B  = 12;
   localparam int EW = 3;
   localparam int CW = 8;
   localparam int CNT_MAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          near = 1'b0;
   logic          present, buzzer, event_pulse;
   logic [EW-1:0] event_count;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;

   presence_alarm #(
      .CNT_W(CW), .CONFIRM_CYC(C), .RELEASE_CYC(R),
      .BEEP_HALF(H), .BEEP_CYC(B), .EVT_W(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .near(near),
      .present(present), .buzzer(buzzer),
      .event_pulse(event_pulse), .event_count(event_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Presence is decided from how many consecutive enabled edges the
   // synchronized flag has held its level: C+1 high edges while absent is
   // an arrival, R+1 low edges while present is a departure.
   bit s_hist[2];
   bit m_last;
   int m_run;
   bit m_pres, m_buz, m_pulse;
   int m_cnt, m_tone, m_half;

   task automatic model_reset();
      s_hist[0] = 0; s_hist[1] = 0;
      m_last = 0; m_run = 0;
      m_pres = 0; m_buz = 0; m_pulse = 0;
      m_cnt = 0; m_tone = 0; m_half = 0;
   endtask

   task automatic model_step();
      bit ns;
      ns = s_hist[1];
      s_hist[1] = s_hist[0];
      s_hist[0] = near;
      m_pulse = 0;
      if (!enable) begin
         m_pres = 0; m_buz = 0; m_tone = 0; m_half = 0; m_run = 0;
         return;
      end
      if (m_run != 0 && ns == m_last) m_run++;
      else m_run = 1;
      m_last = ns;
      if (!m_pres) begin
         m_buz = 0;
         if (ns && m_run == C + 1) begin
            m_pulse = 1;
            m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_pres  = 1;
            m_tone  = 0;
            m_half  = 0;
            m_buz   = (B > 0);
         end
      end else if (ns) begin
         if (m_run == 1) begin
            m_buz = (m_tone < B);              // coming back: tone resumes high
         end else if (m_tone < B) begin
            m_tone++;
            if (m_tone == B) m_buz = 0;
            else if (m_half == H - 1) begin m_buz = !m_buz; m_half = 0; end
            else m_half++;
         end
      end else begin
         m_buz = 0;
         if (m_run == R + 1) m_pres = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("model_present", int'(present), int'(m_pres));
         chk("model_buzzer", int'(buzzer), int'(m_buz));
         chk("model_pulse", int'(event_pulse), int'(m_pulse));
         chk("model_count", int'(event_count), m_cnt);
      end
   end

   initial forever begin
      @(negedge clk);
      if (event_pulse) pulses++;
   end

   // counts edges from the next posedge (edge 0) until the watched output
   // reaches lvl; n = -1 if the bound runs out
   task automatic wait_for(input bit use_pres, input bit lvl, input int lim, output int n);
      n = -1;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if ((use_pres ? present : event_pulse) == lvl) begin
            n = i;
            return;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, p0, run_left;
      logic [EW-1:0] held;

      // reset held with near=1
      enable = 1; near = 1; rst_n = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_present", int'(present), 0);
         chk("rst_buzzer", int'(buzzer), 0);
         chk("rst_pulse", int'(event_pulse), 0);
         chk("rst_count", int'(event_count), 0);
      end
      rst_n = 1;

      // arrival latency and beep burst
      wait_for(0, 1, 40, n);
      chk("arrival_latency", n, C + 2);
      chk("arrival_present", int'(present), 1);
      chk("arrival_count", int'(event_count), 1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         chk($sformatf("beep_seq[%0d]", i), int'(buzzer),
             int'((i < B) && ((i / H) % 2 == 0)));
         if (i == 1) chk("pulse_width", int'(event_pulse), 0);
      end

      // dropout shorter than release time
      @(negedge clk); near = 0;
      repeat (10) @(negedge clk);
      near = 1;
      repeat (6) @(negedge clk);
      chk("dropout_present", int'(present), 1);
      chk("dropout_count", int'(event_count), 1);

      // real departure
      near = 0;
      wait_for(1, 0, 60, n);
      chk("depart_latency", n, R + 2);

      // glitch shorter than confirm time
      @(negedge clk);
      p0 = pulses;
      near = 1;
      repeat (5) @(negedge clk);
      near = 0;
      repeat (12) @(negedge clk);
      chk("glitch_present", int'(present), 0);
      chk("glitch_count", int'(event_count), 1);
      chk("glitch_pulses", pulses - p0, 0);

      // saturation over 9 arrive/release cycles
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      p0 = pulses;
      for (int k = 1; k <= 9; k++) begin
         near = 1;
         repeat (14) @(negedge clk);
         near = 0;
         repeat (22) @(negedge clk);
         chk($sformatf("sat_count[%0d]", k), int'(event_count), (k < CNT_MAX) ? k : CNT_MAX);
      end
      chk("sat_pulses", pulses - p0, 9);

      // enable dropped mid-beep
      near = 1;
      wait_for(0, 1, 40, n);
      chk("abort_arrival", n, C + 2);
      repeat (4) @(negedge clk);
      held = event_count;
      enable = 0;
      @(posedge clk); #1;
      chk("abort_present", int'(present), 0);
      chk("abort_buzzer", int'(buzzer), 0);
      chk("abort_count", int'(event_count), int'(held));
      repeat (3) @(negedge clk);
      enable = 1;
      repeat (20) @(negedge clk);

      // async reset while confirming
      near = 0;
      repeat (22) @(negedge clk);
      near = 1;
      repeat (6) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_rst_count", int'(event_count), 0);
      chk("async_rst_present", int'(present), 0);
      @(negedge clk); rst_n = 1;

      // async reset while present
      wait_for(0, 1, 40, n);
      chk("rearrive_after_rst", n, C + 2);
      #2 rst_n = 0;
      #1;
      chk("async_rst_active_present", int'(present), 0);
      chk("async_rst_active_buzzer", int'(buzzer), 0);
      chk("async_rst_active_count", int'(event_count), 0);
      @(negedge clk); rst_n = 1;

      // randomized runs of near with occasional enable drops
      run_left = 0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if (run_left == 0) begin
            near = ~near;
            run_left = $urandom_range(1, 30);
         end
         run_left--;
         enable = ($urandom_range(0, 39) != 0);
      end
      enable = 1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/presence_alarm.md
Name: presence_alarm

Overview:
- Downstream stage of the sonar distance block. Consumes its 1-bit "object near" flag.
- Qualifies the flag with confirm/release hold timers and tracks presence with a 4-state FSM.
- Drives a piezo buzzer with a bounded square-wave beep burst on each new arrival.
- Counts arrival events for the board status display.
- Runs on the same 64 MHz system clock as the sonar block.

Parameters:
- CNT_W, 26, width of all internal timers; every *_CYC value must fit in CNT_W bits.
- CONFIRM_CYC, 640000, cycles near must stay high before an arrival is accepted (10 ms). Must be ≥1.
- RELEASE_CYC, 6400000, cycles near must stay low before presence is dropped (100 ms). Must be ≥1.
- BEEP_HALF, 32000, buzzer half-period in cycles (1 kHz tone). Must be ≥1.
- BEEP_CYC, 32000000, total tone duration per arrival, in ACTIVE cycles (0.5 s).
- EVT_W, 8, width of the event counter.

Ports:
- clk  input  1  system clock, 64 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low forces IDLE.
- near  input  1  state flag from the sonar stage.
- present  output  1  debounced presence.
- buzzer  output  1  piezo drive.
- event_pulse  output  1  one-cycle strobe per accepted arrival.
- event_count  output  EVT_W  saturating arrival count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - present=0, buzzer=0, event_pulse=0, event_count=0.
  - FSM=IDLE, all timers=0, synchronizer flops=0.
- near passes through a 2-flop synchronizer; its second-stage output is near_s. All decisions use near_s.
- All outputs are registered.
- IDLE:
  - present=0, buzzer=0.
  - enable=1 and near_s=1 → CONFIRM, confirm timer=0.
- CONFIRM:
  - near_s=0 → IDLE, no event.
  - Otherwise the timer increments.
  - On the edge where timer==CONFIRM_CYC-1 and near_s=1 → ACTIVE. Same edge: event_pulse=1 for exactly one cycle, event_count+1 (saturates at 2^EVT_W-1, no wrap), present=1, buzzer=1, beep timer=0, half timer=0.
- Arrival latency: event_pulse and present are high after rising edge CONFIRM_CYC+2, counting the first edge that samples near=1 as edge 0.
- ACTIVE:
  - present=1.
  - While beep timer < BEEP_CYC: beep timer increments; half timer increments; when half timer==BEEP_HALF-1, buzzer toggles and half timer=0.
  - When beep timer reaches BEEP_CYC: buzzer=0 and stays 0 for the rest of this presence.
  - near_s=0 → RELEASE, release timer=0.
- RELEASE:
  - present stays 1; buzzer forced 0; beep and half timers frozen.
  - near_s=1 → back to ACTIVE. This is not a new event. Beep and half timers resume from their frozen values, and buzzer resumes at 1 if the beep is still unfinished.
  - On the edge where release timer==RELEASE_CYC-1 and near_s=0 → IDLE, present=0.
- enable=0:
  - On the next edge, any state → IDLE.
  - present=0, buzzer=0, all timers=0, event_count held.
  - An in-progress CONFIRM is discarded.
- Simultaneous events:
  - Confirm expiry and near_s falling on the same edge: the fall wins (→ IDLE, no event).
  - Release expiry and near_s rising on the same edge: the rise wins (→ ACTIVE).
- rst_n asserted mid-operation clears everything immediately, without waiting for a clock edge.
- event_count is reset only by rst_n.
- Unused FSM encodings → IDLE.

Test Plan:
All scenarios use overrides CONFIRM_CYC=8, RELEASE_CYC=16, BEEP_HALF=2, BEEP_CYC=12, EVT_W=3.
1. Reset: assert rst_n=0 for 3 cycles with near=1 → all outputs 0 throughout; after release, the first event_pulse occurs at edge 10 relative to the first edge sampling near=1.
2. Glitch: near=1 for 5 cycles, then 0 → present, event_pulse and event_count stay 0; FSM returns to IDLE.
3. Arrival: hold near=1 → event_pulse high for exactly one cycle after edge 10; present=1; event_count=1. Buzzer sequence over the 12 ACTIVE cycles is 1,1,0,0,1,1,0,0,1,1,0,0, then constant 0.
4. Dropout:
   - From ACTIVE, near=0 for 10 cycles then 1 → present stays 1, no new event_pulse, event_count unchanged.
   - Then near=0 held → present falls after edge 18, counted from the first low sample.
5. Saturation: 9 complete arrive/release cycles → event_count reads 1..7, then stays 7; event_pulse still fires on each arrival.
6. Abort:
   - enable=0 during ACTIVE mid-beep → present=0 and buzzer=0 after the next edge; event_count held.
   - rst_n=0 during CONFIRM → outputs 0 immediately (asynchronous).
